// File: rtl/dmem_pkg.sv
// Definitions shared by the data-memory responder and the CPU datapath:
// FSM states, transfer-size encodings and the captured-request record.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam logic [3:0] XFER_BYTE  = 4'b0001;
    localparam logic [3:0] XFER_DWORD = 4'b1000;

    typedef struct packed {
        logic        write_enable;
        logic        read_enable;
        logic [3:0]  xfer_size;
        logic [63:0] address;
        logic [63:0] write_data;
    } dmem_req_t;

    function automatic logic [3:0] xfer_bytes(input logic [3:0] size);
        return (size == XFER_DWORD) ? 4'd8 : 4'd1;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the data-memory responder.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic        resp_valid;
    logic [63:0] read_data;
    logic        resp_err;

    modport master (
        output req_valid, address, write_enable, read_enable, write_data, xfer_size,
        input  req_ready, resp_valid, read_data, resp_err
    );

    modport slave (
        input  req_valid, address, write_enable, read_enable, write_data, xfer_size,
        output req_ready, resp_valid, read_data, resp_err
    );

endinterface

// File: rtl/dmem_wait_counter.sv
// 4-bit loadable down-counter that times the wait states before a memory access.
module dmem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       enable,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory with a fixed-latency request/response handshake.
// Requests are captured on acceptance and executed on the edge that enters RESP.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    dmem_state_t               state;
    dmem_req_t                 held;
    dmem_req_t                 live;
    dmem_req_t                 cur;
    logic [DEPTH_BYTES*8-1:0]  mem;
    logic                      accept;
    logic                      enter_resp;
    logic                      cnt_zero;
    logic                      fault;
    logic [AW-1:0]             base;
    logic [AW+2:0]             byte_bit;
    logic [AW+2:0]             dword_bit;
    logic [63:0]               load_word;

    function automatic logic req_fault(input dmem_req_t r);
        logic [64:0] last;
        last = {1'b0, r.address} + {61'd0, xfer_bytes(r.xfer_size)};
        return (r.write_enable && r.read_enable)
            || (r.xfer_size != XFER_BYTE && r.xfer_size != XFER_DWORD)
            || (r.xfer_size == XFER_DWORD && r.address[2:0] != 3'd0)
            || (last > 65'(DEPTH_BYTES));
    endfunction

    assign live = {bus.write_enable, bus.read_enable, bus.xfer_size, bus.address, bus.write_data};
    assign accept = bus.req_valid && bus.req_ready;
    // With zero wait states the access happens on the accepting edge, so use the live inputs.
    assign cur = (state == IDLE) ? live : held;
    assign enter_resp = ((state == IDLE) && accept && (WAIT_STATES == 0))
                     || ((state == WAIT) && cnt_zero);
    assign fault = req_fault(cur);

    assign base      = cur.address[AW-1:0];
    assign byte_bit  = {base, 3'b000};
    assign dword_bit = {base[AW-1:3], 6'b000000};

    always_comb begin
        load_word = '0;
        if (cur.xfer_size == XFER_DWORD) begin
            load_word = mem[dword_bit +: 64];
        end else begin
            load_word[7:0] = mem[byte_bit +: 8];
        end
    end

    dmem_wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (accept && (WAIT_STATES != 0)),
        .load_value (WAIT_LOAD),
        .enable     (state == WAIT),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.read_data  <= '0;
            bus.resp_err   <= 1'b0;
            held           <= '0;
            mem            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        held          <= live;
                        bus.req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_zero) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                bus.resp_err  <= fault;
                bus.read_data <= '0;
                if (!fault && cur.write_enable) begin
                    if (cur.xfer_size == XFER_DWORD) begin
                        mem[dword_bit +: 64] <= cur.write_data;
                    end else begin
                        mem[byte_bit +: 8] <= cur.write_data[7:0];
                    end
                end else if (!fault && cur.read_enable) begin
                    bus.read_data <= load_word;
                end
            end
        end
    end

endmodule
